// File: rtl/p1_alu_core.sv
// Single-operation N-bit ALU leaf: combinational result plus registered copy.
// Optional registered carry/zero/overflow flags when P1_ALU_FLAGS_EN is defined.
module p1_alu_core #(
    parameter int N      = 4,
    parameter int opcode = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    output logic [N-1:0] out,
    output logic [N-1:0] out_q,
`ifdef P1_ALU_FLAGS_EN
    output logic         carry_q,
    output logic         zero_q,
    output logic         ovf_q,
`endif
    output logic         op_err
);

    localparam logic OP_BAD = (opcode < 0) || (opcode > 3);

    logic [N-1:0] res;
`ifdef P1_ALU_FLAGS_EN
    logic carry;
    logic ovf;
`endif

    assign op_err = OP_BAD;
    assign out    = res;

    always_comb begin
        res = '0;
`ifdef P1_ALU_FLAGS_EN
        carry = 1'b0;
        ovf   = 1'b0;
`endif
        case (opcode)
            0: begin
`ifdef P1_ALU_FLAGS_EN
                {carry, res} = {1'b0, in0} + {1'b0, in1};
                ovf = (in0[N-1] == in1[N-1]) && (res[N-1] != in0[N-1]);
`else
                res = in0 + in1;
`endif
            end
            1: res = in0 | in1;
            2: begin
`ifdef P1_ALU_FLAGS_EN
                // Extended bit of the widened difference is the unsigned borrow.
                {carry, res} = {1'b0, in0} - {1'b0, in1};
                ovf = (in0[N-1] != in1[N-1]) && (res[N-1] != in0[N-1]);
`else
                res = in0 - in1;
`endif
            end
            3: res = in0 ^ in1;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
`ifdef P1_ALU_FLAGS_EN
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            out_q   <= res;
`ifdef P1_ALU_FLAGS_EN
            carry_q <= carry;
            zero_q  <= (res == '0);
            ovf_q   <= ovf;
`endif
        end
    end

endmodule

// File: tb/tb_p1_alu_core.sv
// Directed bench for p1_alu_core: one instance per opcode (0..3 and illegal 7), shared operands.
// Flag checks are compiled in only when P1_ALU_FLAGS_EN is defined.
module tb_p1_alu_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a   = '0;
    logic [3:0] b   = '0;

    logic [3:0] add_out, or_out, sub_out, xor_out, bad_out;
    logic [3:0] add_q, or_q, sub_q, xor_q, bad_q;
    logic       add_err, or_err, sub_err, xor_err, bad_err;
`ifdef P1_ALU_FLAGS_EN
    logic add_c, add_z, add_v, or_c, or_z, or_v, sub_c, sub_z, sub_v;
    logic xor_c, xor_z, xor_v, bad_c, bad_z, bad_v;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    p1_alu_core #(.N(4), .opcode(0)) u_add (.clk(clk), .rst(rst), .in0(a), .in1(b),
        .out(add_out), .out_q(add_q),
`ifdef P1_ALU_FLAGS_EN
        .carry_q(add_c), .zero_q(add_z), .ovf_q(add_v),
`endif
        .op_err(add_err));
    p1_alu_core #(.N(4), .opcode(1)) u_or (.clk(clk), .rst(rst), .in0(a), .in1(b),
        .out(or_out), .out_q(or_q),
`ifdef P1_ALU_FLAGS_EN
        .carry_q(or_c), .zero_q(or_z), .ovf_q(or_v),
`endif
        .op_err(or_err));
    p1_alu_core #(.N(4), .opcode(2)) u_sub (.clk(clk), .rst(rst), .in0(a), .in1(b),
        .out(sub_out), .out_q(sub_q),
`ifdef P1_ALU_FLAGS_EN
        .carry_q(sub_c), .zero_q(sub_z), .ovf_q(sub_v),
`endif
        .op_err(sub_err));
    p1_alu_core #(.N(4), .opcode(3)) u_xor (.clk(clk), .rst(rst), .in0(a), .in1(b),
        .out(xor_out), .out_q(xor_q),
`ifdef P1_ALU_FLAGS_EN
        .carry_q(xor_c), .zero_q(xor_z), .ovf_q(xor_v),
`endif
        .op_err(xor_err));
    p1_alu_core #(.N(4), .opcode(7)) u_bad (.clk(clk), .rst(rst), .in0(a), .in1(b),
        .out(bad_out), .out_q(bad_q),
`ifdef P1_ALU_FLAGS_EN
        .carry_q(bad_c), .zero_q(bad_z), .ovf_q(bad_v),
`endif
        .op_err(bad_err));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] ra, rb;

        // Reset state
        edge_step();
        edge_step();
        check("rst_add_q", add_q, 4'h0);
        check("rst_xor_q", xor_q, 4'h0);
        check("rst_sub_q", sub_q, 4'h0);
        check("rst_bad_q", bad_q, 4'h0);
        check("err_add", add_err, 1'b0);
        check("err_or",  or_err,  1'b0);
        check("err_sub", sub_err, 1'b0);
        check("err_xor", xor_err, 1'b0);
        check("err_bad", bad_err, 1'b1);
`ifdef P1_ALU_FLAGS_EN
        check("rst_add_c", add_c, 1'b0);
        check("rst_add_z", add_z, 1'b0);
        check("rst_sub_v", sub_v, 1'b0);
`endif
        rst = 1'b0;

        // XOR 1010 ^ 0110 = 1100; other ops on same operands
        a = 4'b1010; b = 4'b0110;
        #1;
        check("xor_out", xor_out, 4'b1100);
        check("add_wrap", add_out, 4'h0);
        check("or_out1", or_out, 4'b1110);
        check("sub_out1", sub_out, 4'h4);
        check("xor_q_hold", xor_q, 4'h0);
        edge_step();
        check("xor_q", xor_q, 4'hC);
        check("sub_q1", sub_q, 4'h4);

        // Mid-stream reset clears out_q while out keeps tracking inputs
        rst = 1'b1; a = 4'h3; b = 4'h5;
        #1;
        check("pre_rst_xor_q", xor_q, 4'hC);
        edge_step();
        check("midrst_xor_q", xor_q, 4'h0);
        check("midrst_sub_q", sub_q, 4'h0);
        check("midrst_xor_out", xor_out, 4'h6);
        rst = 1'b0;
        edge_step();
        check("resume_xor_q", xor_q, 4'h6);

        // SUB 3 - 5 = E, borrow, no signed overflow
        check("sub_out2", sub_out, 4'hE);
        check("sub_q2", sub_q, 4'hE);
`ifdef P1_ALU_FLAGS_EN
        check("sub_borrow", sub_c, 1'b1);
        check("sub_ovf0", sub_v, 1'b0);
        check("sub_zero0", sub_z, 1'b0);
`endif

        // ADD F + 1 wraps to 0 with carry
        a = 4'hF; b = 4'h1;
        #1;
        check("add_out_f1", add_out, 4'h0);
        edge_step();
        check("add_q_f1", add_q, 4'h0);
`ifdef P1_ALU_FLAGS_EN
        check("add_carry", add_c, 1'b1);
        check("add_zero", add_z, 1'b1);
        check("add_ovf0", add_v, 1'b0);
        check("xor_carry0", xor_c, 1'b0);
`endif

        // OR and illegal opcode
        a = 4'b1000; b = 4'b0001;
        #1;
        check("or_out2", or_out, 4'b1001);
        check("bad_out", bad_out, 4'h0);
        check("add_out81", add_out, 4'h9);
        check("sub_out81", sub_out, 4'h7);
        edge_step();
        check("or_q2", or_q, 4'b1001);
        check("bad_q", bad_q, 4'h0);
`ifdef P1_ALU_FLAGS_EN
        check("sub_ovf_81", sub_v, 1'b1);
        check("sub_noborrow", sub_c, 1'b0);
        check("or_ovf0", or_v, 1'b0);
`endif

        // Signed overflow on ADD 7 + 1 = 8
        a = 4'h7; b = 4'h1;
        #1;
        check("add_out71", add_out, 4'h8);
        edge_step();
        check("add_q71", add_q, 4'h8);
`ifdef P1_ALU_FLAGS_EN
        check("add_ovf71", add_v, 1'b1);
        check("add_carry71", add_c, 1'b0);
        check("add_zero71", add_z, 1'b0);
`endif

        // Random XOR pairs
        for (int i = 0; i < 100; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            a = ra; b = rb;
            #10;
            check("xor_rand", xor_out, ra ^ rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
